// File: rtl/apb4_cmd_master_pkg.sv
// Shared types and constants for the APB4 command master.
package apb4_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int unsigned PPROT_W          = 3;
    localparam int unsigned PPROT_PRIV_BIT   = 0;
    localparam int unsigned PPROT_NONSEC_BIT = 1;
    localparam int unsigned PPROT_INSTR_BIT  = 2;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb4_cmd_master_wdog.sv
// PREADY wait-state watchdog: counts ACCESS cycles without PREADY and flags the last allowed one.
module apb4_cmd_master_wdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Compare the pre-increment value so the abort lands on the TIMEOUT-th wait cycle.
            assign expire_o = en_i && (cnt_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/apb4_cmd_master.sv
// APB4 requester: one valid/ready command in, one APB4 transfer, one valid/ready response out.
// state  | meaning
// IDLE   | ready for a command, APB bus idle
// SETUP  | PSEL high, PENABLE low
// ACCESS | PSEL and PENABLE high, waiting on PREADY or timeout
// RESP   | response held until rsp_ready_i
module apb4_cmd_master
    import apb4_cmd_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256,
    localparam int unsigned STRB_W    = strb_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [STRB_W-1:0]     cmd_strb_i,
    input  logic [PPROT_W-1:0]    cmd_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [PPROT_W-1:0]    pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_W-1:0]     pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [PPROT_W-1:0]    prot_q, prot_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;

    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    assign wd_en = (state_q == ACCESS) && !pready_i;

    apb4_cmd_master_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        wd_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    strb_d  = cmd_write_i ? cmd_strb_i : '0;
                    prot_d  = cmd_prot_i;
                    write_d = cmd_write_i;
                    wd_clr  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout landing in the same cycle.
                if (pready_i) begin
                    rdata_d = write_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_expire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;
    assign paddr_o       = addr_q;
    assign pprot_o       = prot_q;
    assign pwrite_o      = write_q;
    assign pwdata_o      = wdata_q;
    assign pstrb_o       = strb_q;

endmodule
